// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W_DEFAULT = 4;

    // Width of the iteration counter for a W-bit divide. The counter is kept
    // at least one bit wide so that W=1 still elaborates.
    function automatic int div_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step: diff = a - b, done as a + ~b + 1.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a, b (N bits) in; diff (N bits) out; carry_out = 1 when a >= b (no borrow).
module div_trial_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         carry_out
);

    logic [N:0] sum;

    assign sum       = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign diff      = sum[N-1:0];
    assign carry_out = sum[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock from a shared W+1-bit subtractor.
// Latency: W cycles from accepted start to done; divide-by-zero completes on the accepting edge.
// Backpressure: start is only taken in IDLE/DONE; start while busy is ignored.
// Ports: clk, rst (async, active-high); start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out (all registered).
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = div_cnt_w(W);

    div_state_t     state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   dvd_sh;     // dividend bits still to be consumed, MSB first
    logic [W-1:0]   dvs_reg;
    logic [W-1:0]   q_work;
    logic [W:0]     p_reg;      // partial remainder

    logic [W:0]     p_shift;
    logic [W:0]     trial;
    logic           no_borrow;
    logic [W:0]     p_next;
    logic [W-1:0]   q_next;

    // Bring down the next dividend bit into the partial remainder.
    assign p_shift = (p_reg << 1) | {{W{1'b0}}, dvd_sh[W-1]};

    div_trial_sub #(
        .N (W + 1)
    ) u_trial_sub (
        .a         (p_shift),
        .b         ({1'b0, dvs_reg}),
        .diff      (trial),
        .carry_out (no_borrow)
    );

    // Restore on borrow: keep the shifted value and emit a 0 quotient bit.
    assign p_next = no_borrow ? trial : p_shift;
    assign q_next = (q_work << 1) | {{(W-1){1'b0}}, no_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_sh      <= '0;
            dvs_reg     <= '0;
            q_work      <= '0;
            p_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_sh  <= dividend;
                        dvs_reg <= divisor;
                        p_reg   <= '0;
                        q_work  <= '0;
                        if (divisor == '0) begin
                            // No iterations needed: report saturated quotient immediately.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            cnt         <= CW'(W - 1);
                            busy        <= 1'b1;
                            state       <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p_reg  <= p_next;
                    q_work <= q_next;
                    dvd_sh <= dvd_sh << 1;
                    if (cnt == '0) begin
                        // Final step: the partial remainder now fits in W bits.
                        quotient  <= q_next;
                        remainder <= p_next[W-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
